// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register stack, plus the arbiter's read-side state.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE, FETCH, PRESENT
  } rd_state_t;

  localparam int STACK_DEPTH = 2 ** $bits(address_t);

endpackage

// File: rtl/instr_register_rr_arb.sv
// Round-robin grant among NUM_REQ requesters; the priority pointer moves past each winner.
module instr_register_rr_arb #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  input  logic               i_upd,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic          w_found;

  // First requester at or after the pointer, scanning with wrap.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[IW'((int'(r_ptr) + k) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_idx   = IW'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign o_gnt = (w_found && i_en) ? (NUM_REQ'(1) << w_idx) : '0;
  assign o_idx = w_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_upd) begin
      r_ptr <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
    end
  end

endmodule

// File: rtl/instr_register_arbiter.sv
// Shares the instruction register stack as a tagged FIFO: round-robin write side,
// one-entry presentation register on the read side.
module instr_register_arbiter
  import instr_register_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DEPTH   = 32,
  localparam int SW      = $clog2(NUM_REQ),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic     [NUM_REQ-1:0]   req_valid,
  output logic     [NUM_REQ-1:0]   req_ready,
  input  opcode_t  [NUM_REQ-1:0]   req_opcode,
  input  operand_t [NUM_REQ-1:0]   req_operand_a,
  input  operand_t [NUM_REQ-1:0]   req_operand_b,
  output logic                     load_en,
  output address_t                 write_pointer,
  output opcode_t                  opcode,
  output operand_t                 operand_a,
  output operand_t                 operand_b,
  output address_t                 read_pointer,
  input  instruction_t             instruction_word,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output instruction_t             rd_instruction,
  output logic     [SW-1:0]        rd_source,
  output logic     [CW-1:0]        count
);

  logic [NUM_REQ-1:0] w_gnt;
  logic [SW-1:0]      w_idx;
  logic               w_en, w_xfer, w_pop;
  logic [CW-1:0]      w_committed_nxt;

  address_t     r_wptr, r_rptr, r_wp_out;
  logic         r_load_en;
  opcode_t      r_opc;
  operand_t     r_a, r_b;
  logic [CW-1:0] r_count, r_committed;
  logic [SW-1:0] r_tag [DEPTH];
  rd_state_t    r_state;
  logic         r_rd_valid;
  instruction_t r_rd_ins;
  logic [SW-1:0] r_rd_src;

  // count tracks reserved slots, so a full stack blocks grants even before writes land.
  assign w_en   = reset_n && (r_count != CW'(DEPTH));
  assign w_xfer = |(req_valid & w_gnt);
  assign w_pop  = r_rd_valid & rd_ready;

  instr_register_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (clk),
    .reset_n(reset_n),
    .i_req  (req_valid),
    .i_en   (w_en),
    .i_upd  (w_xfer),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_en <= 1'b0;
      r_wptr    <= '0;
      r_wp_out  <= '0;
      r_opc     <= ZERO;
      r_a       <= '0;
      r_b       <= '0;
      r_count   <= '0;
    end else begin
      r_load_en <= w_xfer;
      if (w_xfer) begin
        r_opc    <= req_opcode[w_idx];
        r_a      <= req_operand_a[w_idx];
        r_b      <= req_operand_b[w_idx];
        r_wp_out <= r_wptr;
        r_wptr   <= r_wptr + address_t'(1);
      end
      case ({w_xfer, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Tags need no reset: an entry is only read after its own write has landed.
  always_ff @(posedge clk) begin
    if (w_xfer) r_tag[r_wptr] <= w_idx;
  end

  always_comb begin
    case ({r_load_en, w_pop})
      2'b10:   w_committed_nxt = r_committed + CW'(1);
      2'b01:   w_committed_nxt = r_committed - CW'(1);
      default: w_committed_nxt = r_committed;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_committed <= '0;
      r_state     <= IDLE;
      r_rptr      <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_ins    <= '0;
      r_rd_src    <= '0;
    end else begin
      r_committed <= w_committed_nxt;
      case (r_state)
        IDLE: begin
          if (r_committed != '0) r_state <= FETCH;
        end
        FETCH: begin
          r_rd_ins   <= instruction_word;
          r_rd_src   <= r_tag[r_rptr];
          r_rd_valid <= 1'b1;
          r_state    <= PRESENT;
        end
        PRESENT: begin
          if (w_pop) begin
            r_rd_valid <= 1'b0;
            r_rptr     <= r_rptr + address_t'(1);
            r_state    <= (w_committed_nxt != '0) ? FETCH : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready      = w_gnt;
  assign load_en        = r_load_en;
  assign write_pointer  = r_wp_out;
  assign opcode         = r_opc;
  assign operand_a      = r_a;
  assign operand_b      = r_b;
  assign read_pointer   = r_rptr;
  assign rd_valid       = r_rd_valid;
  assign rd_instruction = r_rd_ins;
  assign rd_source      = r_rd_src;
  assign count          = r_count;

endmodule
